// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand/result valid-ready bus of the pipelined adder/subtractor
interface pipelined_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: carry-segmented pipelined two's-complement adder/subtractor with valid/ready
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_width_check
        $error("WIDTH must be a multiple of STAGES");
    end

    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d, v_q;
    logic [CW:0]       t;
    logic              ci;
    logic              stall;

    assign stall        = v_q[L] && !bus.out_ready;
    assign bus.in_ready = !stall;

    // Stage k adds chunk k; stage 0 sees the effective operands straight off the bus.
    always_comb begin
        t   = '0;
        ci  = 1'b0;
        c_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = k == 0 ? bus.in_a : a_q[k == 0 ? 0 : k - 1];
            b_d[k] = k == 0 ? (bus.in_sub ? ~bus.in_b : bus.in_b) : b_q[k == 0 ? 0 : k - 1];
            s_d[k] = k == 0 ? '0 : s_q[k == 0 ? 0 : k - 1];
            ci     = k == 0 ? bus.in_sub ^ bus.in_cin : c_q[k == 0 ? 0 : k - 1];
            t      = {1'b0, a_d[k][k*CW +: CW]} + {1'b0, b_d[k][k*CW +: CW]} + (CW + 1)'(ci);
            s_d[k][k*CW +: CW] = t[CW-1:0];
            c_d[k] = t[CW];
        end
    end

    // A global stall freezes every stage; otherwise all stages advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                v_q[k] <= k == 0 ? bus.in_valid : v_q[k == 0 ? 0 : k - 1];
            end
            c_q <= c_d;
        end
    end

    assign bus.out_valid = v_q[L];
    assign bus.out_sum   = s_q[L];
    assign bus.out_cout  = c_q[L];
    assign bus.out_ovf   = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: randomized and directed self-checking bench for pipelined_add_sub
module tb_pipelined_add_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(32)) m();
    pipelined_add_sub_if #(.WIDTH(16)) w1();
    pipelined_add_sub_if #(.WIDTH(16)) w16();
    pipelined_add_sub_if #(.WIDTH(64)) w64();

    pipelined_add_sub #(.WIDTH(32), .STAGES(4))  dut     (.clk(clk), .rst_n(rst_n), .bus(m));
    pipelined_add_sub #(.WIDTH(16), .STAGES(1))  dut_w1  (.clk(clk), .rst_n(rst_n), .bus(w1));
    pipelined_add_sub #(.WIDTH(16), .STAGES(16)) dut_w16 (.clk(clk), .rst_n(rst_n), .bus(w16));
    pipelined_add_sub #(.WIDTH(64), .STAGES(8))  dut_w64 (.clk(clk), .rst_n(rst_n), .bus(w64));

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t q[$];

    // Reference: exact integer arithmetic, unsigned for sum/carry and signed for overflow.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        res_t   r;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint c  = cin ? 64'sd1 : 64'sd0;
        longint u  = sub ? ua - ub - c : ua + ub + c;
        longint s  = sub ? sa - sb - c : sa + sb + c;
        r.sum  = u[31:0];
        r.cout = sub ? (u >= 0) : u[32];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                            output res_t r, output int lat);
        m.in_a = a; m.in_b = b; m.in_cin = cin; m.in_sub = sub;
        m.in_valid = 1'b1; m.out_ready = 1'b1;
        tick;
        m.in_valid = 1'b0;
        lat = 1;
        while (!m.out_valid && lat < 20) begin
            tick;
            lat++;
        end
        r.sum = m.out_sum; r.cout = m.out_cout; r.ovf = m.out_ovf;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({m.out_valid, m.out_sum, m.out_cout, m.out_ovf, m.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b s=%h c=%b o=%b r=%b expected v=0 s=0 c=0 o=0 r=1",
                     m.out_valid, m.out_sum, m.out_cout, m.out_ovf, m.in_ready);
        end
        n_cmp++;
        if ({w1.out_valid, w16.out_valid, w64.out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_sweep_valid: got %b expected 000", {w1.out_valid, w16.out_valid, w64.out_valid});
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_carry_ripple;
        res_t r;
        int   lat;
        run_beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, r, lat);
        n_cmp++;
        if ({r.sum, r.cout, r.ovf} !== {32'h0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ripple_result: got s=%h c=%b o=%b expected s=00000000 c=1 o=0", r.sum, r.cout, r.ovf);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL ripple_latency: got %0d expected 4", lat);
        end
    endtask

    task automatic test_subtract;
        res_t r;
        int   lat;
        run_beat(32'd5, 32'd7, 1'b0, 1'b1, r, lat);
        n_cmp++;
        if ({r.sum, r.cout, r.ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: got s=%h c=%b o=%b expected s=fffffffe c=0 o=0", r.sum, r.cout, r.ovf);
        end
        run_beat(32'd7, 32'd5, 1'b1, 1'b1, r, lat);
        n_cmp++;
        if ({r.sum, r.cout, r.ovf} !== {32'h1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow_in: got s=%h c=%b o=%b expected s=00000001 c=1 o=0", r.sum, r.cout, r.ovf);
        end
    endtask

    task automatic test_overflow;
        res_t r;
        int   lat;
        run_beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r, lat);
        n_cmp++;
        if ({r.sum, r.cout, r.ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_add: got s=%h c=%b o=%b expected s=80000000 c=0 o=1", r.sum, r.cout, r.ovf);
        end
        run_beat(32'h8000_0000, 32'h1, 1'b0, 1'b1, r, lat);
        n_cmp++;
        if ({r.sum, r.cout, r.ovf} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_sub: got s=%h c=%b o=%b expected s=7fffffff c=1 o=1", r.sum, r.cout, r.ovf);
        end
    endtask

    // Streams n random beats; with bp set, out_ready is toggled pseudo-randomly.
    task automatic test_stream(input int n, input bit bp);
        int          sent = 0, got = 0, cyc = 0, first = -1, last = -1;
        bit          was_stall = 1'b0;
        res_t        held, exp;
        logic [31:0] a = $urandom, b = $urandom;
        logic        cin = 1'($urandom), sub = 1'($urandom);
        q.delete();
        while ((sent < n || got < n) && cyc < 2000) begin
            m.in_valid = sent < n;
            m.in_a = a; m.in_b = b; m.in_cin = cin; m.in_sub = sub;
            m.out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            n_cmp++;
            if (m.in_ready !== !(m.out_valid && !m.out_ready)) begin
                n_err++;
                $display("FAIL in_ready_rule: got %b expected %b at cycle %0d", m.in_ready,
                         !(m.out_valid && !m.out_ready), cyc);
            end
            if (was_stall) begin
                n_cmp++;
                if ({m.out_valid, m.out_sum, m.out_cout, m.out_ovf} !== {1'b1, held.sum, held.cout, held.ovf}) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b", m.out_valid,
                             m.out_sum, m.out_cout, m.out_ovf, held.sum, held.cout, held.ovf);
                end
            end
            if (m.out_valid && m.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra: got s=%h expected no output", m.out_sum);
                end else begin
                    exp = q.pop_front();
                    if ({m.out_sum, m.out_cout, m.out_ovf} !== {exp.sum, exp.cout, exp.ovf}) begin
                        n_err++;
                        $display("FAIL stream_result #%0d: got s=%h c=%b o=%b expected s=%h c=%b o=%b", got,
                                 m.out_sum, m.out_cout, m.out_ovf, exp.sum, exp.cout, exp.ovf);
                    end
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            was_stall = m.out_valid && !m.out_ready;
            held.sum = m.out_sum; held.cout = m.out_cout; held.ovf = m.out_ovf;
            if (m.in_valid && m.in_ready) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
                a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            end
            tick;
            cyc++;
        end
        m.in_valid = 1'b0;
        m.out_ready = 1'b1;
        n_cmp++;
        if (got != n || q.size() != 0) begin
            n_err++;
            $display("FAIL stream_count: got %0d results (%0d pending) expected %0d", got, q.size(), n);
        end
        if (!bp) begin
            n_cmp++;
            if (last - first + 1 != n) begin
                n_err++;
                $display("FAIL back_to_back_gap: got span %0d expected %0d", last - first + 1, n);
            end
        end
        tick;
    endtask

    task automatic test_reset_midflight;
        res_t r;
        int   lat;
        int   stale = 0;
        m.out_ready = 1'b1;
        m.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m.in_a = $urandom; m.in_b = $urandom; m.in_cin = 1'b0; m.in_sub = 1'b0;
            tick;
        end
        m.in_valid = 1'b0;
        tick;
        n_cmp++;
        if (m.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_pre_valid: got %b expected 1", m.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m.out_valid, m.out_sum, m.out_cout, m.out_ovf, m.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL midflight_reset: got v=%b s=%h c=%b o=%b r=%b expected v=0 s=0 c=0 o=0 r=1",
                     m.out_valid, m.out_sum, m.out_cout, m.out_ovf, m.in_ready);
        end
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (m.out_valid) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL midflight_stale: got %0d valid cycles expected 0", stale);
        end
        run_beat(32'd2, 32'd3, 1'b0, 1'b0, r, lat);
        n_cmp++;
        if ({r.sum, lat} !== {32'd5, 32'd4}) begin
            n_err++;
            $display("FAIL midflight_new_beat: got s=%h lat=%0d expected s=00000005 lat=4", r.sum, lat);
        end
    endtask

    task automatic test_param_sweep;
        int          l1 = 0, l16 = 0, l64 = 0;
        logic [16:0] r1 = '1, r16 = '1;
        logic [64:0] r64 = '1;
        w1.in_a = '1;  w1.in_b = 16'h1;  w1.in_valid = 1'b1;
        w16.in_a = '1; w16.in_b = 16'h1; w16.in_valid = 1'b1;
        w64.in_a = '1; w64.in_b = 64'h1; w64.in_valid = 1'b1;
        tick;
        w1.in_valid = 1'b0; w16.in_valid = 1'b0; w64.in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (l1 == 0 && w1.out_valid) begin l1 = c; r1 = {w1.out_cout, w1.out_sum}; end
            if (l16 == 0 && w16.out_valid) begin l16 = c; r16 = {w16.out_cout, w16.out_sum}; end
            if (l64 == 0 && w64.out_valid) begin l64 = c; r64 = {w64.out_cout, w64.out_sum}; end
            tick;
        end
        n_cmp++;
        if (r1 !== {1'b1, 16'h0} || l1 != 1) begin
            n_err++;
            $display("FAIL sweep_16x1: got cout_sum=%h lat=%0d expected 10000 lat=1", r1, l1);
        end
        n_cmp++;
        if (r16 !== {1'b1, 16'h0} || l16 != 16) begin
            n_err++;
            $display("FAIL sweep_16x16: got cout_sum=%h lat=%0d expected 10000 lat=16", r16, l16);
        end
        n_cmp++;
        if (r64 !== {1'b1, 64'h0} || l64 != 8) begin
            n_err++;
            $display("FAIL sweep_64x8: got cout_sum=%h lat=%0d expected 1_0000000000000000 lat=8", r64, l64);
        end
    endtask

    initial begin
        m.in_valid = 1'b0; m.in_a = '0; m.in_b = '0; m.in_cin = 1'b0; m.in_sub = 1'b0; m.out_ready = 1'b1;
        w1.in_valid = 1'b0; w1.in_a = '0; w1.in_b = '0; w1.in_cin = 1'b0; w1.in_sub = 1'b0; w1.out_ready = 1'b1;
        w16.in_valid = 1'b0; w16.in_a = '0; w16.in_b = '0; w16.in_cin = 1'b0; w16.in_sub = 1'b0; w16.out_ready = 1'b1;
        w64.in_valid = 1'b0; w64.in_a = '0; w64.in_b = '0; w64.in_cin = 1'b0; w64.in_sub = 1'b0; w64.out_ready = 1'b1;
        test_reset;
        test_carry_ripple;
        test_subtract;
        test_overflow;
        test_stream(16, 1'b0);
        test_stream(64, 1'b1);
        test_reset_midflight;
        test_param_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
